aes_stream_ctrl: RTL

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

---
 rtl/aes_stream_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_stream_ctrl.sv
// Streams single-block AES jobs through a register-mapped AES core (slot 0):
// configure, load key (cached), load block, start, poll STATUS, read result.
module aes_stream_ctrl #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int SETTLE_CYC  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_block_i,
  input  logic [127:0] in_key_i,
  input  logic         in_decrypt_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         out_err_o,
  output logic         aes_cs_o,
  output logic         aes_we_o,
  output logic [31:0]  aes_addr_o,
  output logic [31:0]  aes_wdata_o,
  input  logic [31:0]  aes_rdata_i,
  output logic         err_o
);

  // Slot-0 register map and bit positions of the AES core.
  localparam logic [31:0] ADDR_CTRL    = 32'h0000_0000;
  localparam logic [31:0] ADDR_CONFIG  = 32'h0000_0004;
  localparam logic [31:0] ADDR_KEY0    = 32'h0000_0010;
  localparam logic [31:0] ADDR_BLOCK0  = 32'h0000_0020;
  localparam logic [31:0] ADDR_START   = 32'h0000_0030;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0034;
  localparam logic [31:0] ADDR_RESULT0 = 32'h0000_0040;
  localparam int CTRL_ON0_BIT     = 0;
  localparam int CTRL_ENCDEC0_BIT = 0;
  localparam int START_BIT        = 0;
  localparam int STATUS_VALID_BIT = 1;

  localparam int PCW = $clog2(TIMEOUT_CYC + 1);
  localparam int SCW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [PCW-1:0] POLL_LAST   = PCW'(TIMEOUT_CYC - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [3:0] {
    INIT, IDLE, CFG, KEY, BLK, START, SETTLE, POLL, READ, OUT
  } state_t;

  state_t         state_reg, state_next;
  logic [1:0]     word_cnt_reg, word_cnt_next;
  logic [SCW-1:0] settle_cnt_reg, settle_cnt_next;
  logic [PCW-1:0] poll_cnt_reg, poll_cnt_next;
  logic           init_arm_reg, init_arm_next;
  logic [127:0]   block_reg, block_next;
  logic [127:0]   key_reg, key_next;
  logic           decrypt_reg, decrypt_next;
  logic [127:0]   key_cache_reg, key_cache_next;
  logic           key_loaded_reg, key_loaded_next;
  logic [127:0]   out_data_reg, out_data_next;
  logic           out_err_reg, out_err_next;
  logic           err_reg, err_next;

  logic [31:0]    key_word [4];
  logic [31:0]    blk_word [4];
  logic [31:0]    word_off;
  logic           key_hit;

  // Write order on the bus is MSW first, then the remaining words from the LSW up.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_wr_lane
    localparam int LANE = (gi == 0) ? 3 : gi - 1;
    assign key_word[gi] = key_reg[LANE*32 +: 32];
    assign blk_word[gi] = block_reg[LANE*32 +: 32];
  end

  assign word_off = {28'd0, word_cnt_reg, 2'b00};
  assign key_hit  = key_loaded_reg && (key_reg == key_cache_reg);

  always_comb begin
    state_next      = state_reg;
    word_cnt_next   = word_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    poll_cnt_next   = poll_cnt_reg;
    init_arm_next   = init_arm_reg;
    block_next      = block_reg;
    key_next        = key_reg;
    decrypt_next    = decrypt_reg;
    key_cache_next  = key_cache_reg;
    key_loaded_next = key_loaded_reg;
    out_data_next   = out_data_reg;
    out_err_next    = out_err_reg;
    err_next        = err_reg;
    aes_cs_o        = 1'b0;
    aes_we_o        = 1'b0;
    aes_addr_o      = 32'd0;
    aes_wdata_o     = 32'd0;
    in_ready_o      = 1'b0;
    out_valid_o     = 1'b0;

    unique case (state_reg)
      INIT: begin
        // One quiet cycle after reset release, then the ON write.
        if (!init_arm_reg) begin
          init_arm_next = 1'b1;
        end else begin
          aes_cs_o    = 1'b1;
          aes_we_o    = 1'b1;
          aes_addr_o  = ADDR_CTRL;
          aes_wdata_o = 32'd1 << CTRL_ON0_BIT;
          state_next  = IDLE;
        end
      end
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          block_next    = in_block_i;
          key_next      = in_key_i;
          decrypt_next  = in_decrypt_i;
          out_data_next = 128'd0;
          out_err_next  = 1'b0;
          state_next    = CFG;
        end
      end
      CFG: begin
        aes_cs_o      = 1'b1;
        aes_we_o      = 1'b1;
        aes_addr_o    = ADDR_CONFIG;
        aes_wdata_o   = {31'd0, ~decrypt_reg} << CTRL_ENCDEC0_BIT;
        word_cnt_next = 2'd0;
        state_next    = key_hit ? BLK : KEY;
      end
      KEY: begin
        aes_cs_o      = 1'b1;
        aes_we_o      = 1'b1;
        aes_addr_o    = ADDR_KEY0 + word_off;
        aes_wdata_o   = key_word[word_cnt_reg];
        word_cnt_next = word_cnt_reg + 2'd1;
        if (word_cnt_reg == 2'd3) begin
          key_cache_next  = key_reg;
          key_loaded_next = 1'b1;
          state_next      = BLK;
        end
      end
      BLK: begin
        aes_cs_o      = 1'b1;
        aes_we_o      = 1'b1;
        aes_addr_o    = ADDR_BLOCK0 + word_off;
        aes_wdata_o   = blk_word[word_cnt_reg];
        word_cnt_next = word_cnt_reg + 2'd1;
        if (word_cnt_reg == 2'd3) begin
          state_next = START;
        end
      end
      START: begin
        aes_cs_o        = 1'b1;
        aes_we_o        = 1'b1;
        aes_addr_o      = ADDR_START;
        aes_wdata_o     = 32'd1 << START_BIT;
        settle_cnt_next = '0;
        poll_cnt_next   = '0;
        state_next      = (SETTLE_CYC > 0) ? SETTLE : POLL;
      end
      SETTLE: begin
        // The core still reports the previous job's valid bit here.
        if (settle_cnt_reg == SETTLE_LAST) begin
          poll_cnt_next = '0;
          state_next    = POLL;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end
      POLL: begin
        aes_cs_o   = 1'b1;
        aes_addr_o = ADDR_STATUS;
        if (aes_rdata_i[STATUS_VALID_BIT]) begin
          word_cnt_next = 2'd0;
          state_next    = READ;
        end else if (poll_cnt_reg == POLL_LAST) begin
          out_data_next   = 128'd0;
          out_err_next    = 1'b1;
          err_next        = 1'b1;
          key_loaded_next = 1'b0;
          state_next      = OUT;
        end else begin
          poll_cnt_next = poll_cnt_reg + 1'b1;
        end
      end
      READ: begin
        aes_cs_o      = 1'b1;
        aes_addr_o    = ADDR_RESULT0 + word_off;
        word_cnt_next = word_cnt_reg + 2'd1;
        unique case (word_cnt_reg)
          2'd0: out_data_next[31:0]   = aes_rdata_i;
          2'd1: out_data_next[127:96] = aes_rdata_i;
          2'd2: out_data_next[95:64]  = aes_rdata_i;
          default: out_data_next[63:32] = aes_rdata_i;
        endcase
        if (word_cnt_reg == 2'd3) begin
          state_next = OUT;
        end
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= INIT;
      word_cnt_reg   <= 2'd0;
      settle_cnt_reg <= '0;
      poll_cnt_reg   <= '0;
      init_arm_reg   <= 1'b0;
      block_reg      <= 128'd0;
      key_reg        <= 128'd0;
      decrypt_reg    <= 1'b0;
      key_cache_reg  <= 128'd0;
      key_loaded_reg <= 1'b0;
      out_data_reg   <= 128'd0;
      out_err_reg    <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      poll_cnt_reg   <= poll_cnt_next;
      init_arm_reg   <= init_arm_next;
      block_reg      <= block_next;
      key_reg        <= key_next;
      decrypt_reg    <= decrypt_next;
      key_cache_reg  <= key_cache_next;
      key_loaded_reg <= key_loaded_next;
      out_data_reg   <= out_data_next;
      out_err_reg    <= out_err_next;
      err_reg        <= err_next;
    end
  end

  assign out_data_o = out_data_reg;
  assign out_err_o  = out_err_reg;
  assign err_o      = err_reg;

endmodule
